// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage MIPS pipeline
module pipeline_stall_controller #(
  parameter int unsigned MD_CYCLES   = 32,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [5:0] MD_INIT    = 6'(MD_CYCLES - 1);
  localparam logic [9:0] WAIT_LIMIT = 10'(MEM_TIMEOUT);
  localparam logic [9:0] WAIT_MAX   = 10'd1023;

  state_t           state_q, state_d;
  logic [5:0]       md_cnt_q, md_cnt_d;
  logic [9:0]       wait_cnt_q, wait_cnt_d;
  logic             md_release_q, md_release_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use;
  logic eval_run;
  logic pc_write_raw;
  logic if_id_write_raw;
  logic if_id_flush_raw;
  logic id_ex_bubble_raw;
  logic pipe_hold_raw;

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Next-state and raw control outputs; MEM_WAIT with ready falls back to RUN arbitration
  always_comb begin
    state_d          = state_q;
    md_cnt_d         = md_cnt_q;
    wait_cnt_d       = wait_cnt_q;
    md_release_d     = 1'b0;
    mem_timeout_d    = mem_timeout_q;
    pc_write_raw     = 1'b1;
    if_id_write_raw  = 1'b1;
    if_id_flush_raw  = 1'b0;
    id_ex_bubble_raw = 1'b0;
    pipe_hold_raw    = 1'b0;
    eval_run         = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          pipe_hold_raw   = 1'b1;
          pc_write_raw    = 1'b0;
          if_id_write_raw = 1'b0;
          state_d         = MEM_WAIT;
          wait_cnt_d      = 10'd1;
        end else begin
          eval_run = 1'b1;
        end
      end
      MD_WAIT: begin
        pipe_hold_raw   = 1'b1;
        pc_write_raw    = 1'b0;
        if_id_write_raw = 1'b0;
        md_cnt_d        = md_cnt_q - 6'd1;
        if (md_cnt_q == 6'd1) begin
          state_d      = RUN;
          md_release_d = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          pipe_hold_raw   = 1'b1;
          pc_write_raw    = 1'b0;
          if_id_write_raw = 1'b0;
          wait_cnt_d      = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 10'd1;
        end else begin
          state_d    = RUN;
          wait_cnt_d = 10'd0;
          eval_run   = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (eval_run) begin
      if (ex_branch_taken) begin
        if_id_flush_raw  = 1'b1;
        id_ex_bubble_raw = 1'b1;
      end else if (ex_md_start && !md_release_q) begin
        pipe_hold_raw   = 1'b1;
        pc_write_raw    = 1'b0;
        if_id_write_raw = 1'b0;
        state_d         = MD_WAIT;
        md_cnt_d        = MD_INIT;
      end else if (load_use) begin
        pc_write_raw     = 1'b0;
        if_id_write_raw  = 1'b0;
        id_ex_bubble_raw = 1'b1;
      end
    end

    if (wait_cnt_d >= WAIT_LIMIT) begin
      mem_timeout_d = 1'b1;
    end
  end

  // Final outputs: reset override, and pc_write gated by pipe_hold so unknown inputs cannot assert both
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    pipe_hold    = 1'b0;
    if (rst_n) begin
      pipe_hold    = pipe_hold_raw;
      pc_write     = pc_write_raw & ~pipe_hold_raw;
      if_id_write  = if_id_write_raw & ~pipe_hold_raw;
      if_id_flush  = if_id_flush_raw;
      id_ex_bubble = id_ex_bubble_raw;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      md_cnt_q      <= 6'd0;
      wait_cnt_q    <= 10'd0;
      md_release_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      md_release_q  <= md_release_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

  localparam int MD = 4;
  localparam int TO = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, ex_branch_taken, ex_md_start, mem_req, mem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout;
  logic [CW-1:0] stall_count;

  pipeline_stall_controller #(.MD_CYCLES(MD), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_md_start(ex_md_start), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining frozen mult/div cycles, memory-wait length, stall tally
  int m_md_left, m_wait, m_cnt;
  bit m_in_mem, m_release, m_timeout;
  bit e_pc, e_ifw, e_fl, e_bb, e_hold, e_mem_stall, e_md_go;
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_md_left = 0; m_wait = 0; m_cnt = 0;
    m_in_mem = 0; m_release = 0; m_timeout = 0;
  endtask

  task automatic model_eval();
    bit lu;
    lu = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
    e_pc = 1; e_ifw = 1; e_fl = 0; e_bb = 0; e_hold = 0;
    e_mem_stall = 0; e_md_go = 0;
    if (!rst_n) begin
      e_pc = 0; e_ifw = 0; e_fl = 1; e_bb = 1; e_hold = 0;
    end else if (m_md_left > 0) begin
      e_pc = 0; e_ifw = 0; e_hold = 1;
    end else if (m_in_mem ? !mem_ready : (mem_req && !mem_ready)) begin
      e_pc = 0; e_ifw = 0; e_hold = 1; e_mem_stall = 1;
    end else if (ex_branch_taken) begin
      e_fl = 1; e_bb = 1;
    end else if (ex_md_start && !m_release) begin
      e_pc = 0; e_ifw = 0; e_hold = 1; e_md_go = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_bb = 1;
    end
  endtask

  task automatic model_edge();
    bit rel;
    rel = 0;
    if (!e_pc && m_cnt < 65535) m_cnt++;
    if (m_md_left > 0) begin
      m_md_left--;
      if (m_md_left == 0) rel = 1;
    end else if (e_mem_stall) begin
      m_in_mem = 1;
      m_wait = (m_wait >= 1023) ? 1023 : m_wait + 1;
      if (m_wait >= TO) m_timeout = 1;
    end else begin
      m_in_mem = 0;
      m_wait = 0;
      if (e_md_go) m_md_left = MD - 1;
    end
    m_release = rel;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_write"},     32'(pc_write),     32'(e_pc));
    chk({tag, ".if_id_write"},  32'(if_id_write),  32'(e_ifw));
    chk({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e_fl));
    chk({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bb));
    chk({tag, ".pipe_hold"},    32'(pipe_hold),    32'(e_hold));
    chk({tag, ".mem_timeout"},  32'(mem_timeout),  32'(m_timeout));
    chk({tag, ".stall_count"},  32'(stall_count),  32'(m_cnt));
  endtask

  // Inputs are driven at posedge+1; outputs checked at posedge+3; model advances on the edge
  task automatic step(input string tag);
    #2;
    model_eval();
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rt = 0; ex_mem_read = 0;
    ex_branch_taken = 0; ex_md_start = 0; mem_req = 0; mem_ready = 1;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 0;
    idle_inputs();
    #1;
    model_reset();
    model_eval();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    apply_reset("reset");
    step("idle");

    ex_mem_read = 1; ex_rt = 8; id_rs = 8;
    step("lu_rs");
    idle_inputs();
    step("lu_after");
    chk("lu_count", 32'(stall_count), 32'd1);

    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    step("lu_rt0");
    ex_rt = 9; id_rt = 9; id_rs = 3; id_uses_rt = 1;
    step("lu_rt");
    id_uses_rt = 0;
    step("lu_rt_unused");

    base = m_cnt;
    ex_rt = 8; id_rs = 8; ex_branch_taken = 1;
    step("br_lu");
    idle_inputs();
    step("br_after");
    chk("br_count", 32'(stall_count), 32'(base));

    base = m_cnt;
    ex_md_start = 1;
    for (int i = 0; i < MD + 1; i++) step($sformatf("md_%0d", i));
    chk("md_count", 32'(stall_count), 32'(base + MD));
    ex_md_start = 0;
    step("md_done");

    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) step($sformatf("mw_%0d", i));
    mem_ready = 1; ex_branch_taken = 1;
    step("mw_ready_br");
    idle_inputs();
    step("mw_after");

    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 7; i++) step($sformatf("to_%0d", i));
    mem_ready = 1; mem_req = 0;
    step("to_ready");
    step("to_after");
    chk("to_sticky", 32'(mem_timeout), 32'd1);

    mem_req = 1'bx; ex_md_start = 1'bx; ex_branch_taken = 1'bx; mem_ready = 1'bx;
    #2;
    chk("x_safe", 32'(pc_write === 1'b1 && pipe_hold === 1'b1), 32'd0);
    apply_reset("reset2");
    chk("to_cleared", 32'(mem_timeout), 32'd0);

    ex_md_start = 1;
    step("mdr_0");
    step("mdr_1");
    #1;
    rst_n = 0;
    #1;
    model_reset();
    model_eval();
    check_all("mdr_async");
    apply_reset("mdr_reset");
    step("mdr_run");

    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) apply_reset("rnd_reset");
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_md_start     = ($urandom_range(0, 9) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = 1'($urandom_range(0, 1));
      step($sformatf("rnd_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Arbitrates four hazard sources and drives all PC and pipeline-register enables and flushes:
  - load-use data hazard
  - taken branch/jump resolved in EX
  - multi-cycle mult/div occupying EX
  - data-memory wait
- Adds a multi-cycle FSM, a mult/div latency counter, a memory-wait timeout and a saturating stall counter on top of single-cycle load-use detection.

Parameters:
- MD_CYCLES, 32: total stall cycles for a mult/div in EX; legal range 2..63.
- MEM_TIMEOUT, 255: consecutive MEM_WAIT cycles after which mem_timeout sets; legal range 1..1023.
- CNT_W, 16: stall_count width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_rt  in  5  destination rt of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- ex_md_start  in  1  EX holds a mult/div
- mem_req  in  1  MEM stage accessing data memory
- mem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_bubble  out  1  ID/EX loads NOP (control zeroed)
- pipe_hold  out  1  freezes ID/EX, EX/MEM, MEM/WB
- mem_timeout  out  1  sticky memory-timeout error
- stall_count  out  CNT_W  cycles with pc_write=0, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, counters=0, mem_timeout=0, stall_count=0, md_release=0.
  - Outputs while low: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
  - Reset mid-stall abandons the stall; first cycle after release evaluates as RUN.
- Outputs are combinational from state and inputs (Mealy). State and counters update on the clk rising edge.
- Load-use hit = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Default (no event): pc_write=1, if_id_write=1, all other control outputs 0.
- RUN priority, highest first:
  1. mem_req & !mem_ready: pipe_hold=1, pc_write=0, if_id_write=0. Next state MEM_WAIT, wait counter=1. ex_branch_taken is ignored; EX is frozen and re-presents it later.
  2. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. Load-use and mult/div start in the same cycle are suppressed.
  3. ex_md_start & !md_release: pipe_hold=1, pc_write=0, if_id_write=0. Next state MD_WAIT, md counter=MD_CYCLES-1.
  4. Load-use hit: pc_write=0, if_id_write=0, id_ex_bubble=1. One cycle only; no state change.
- MD_WAIT:
  - Hold outputs as in item 3; md counter decrements each cycle.
  - On the cycle the counter equals 1: next state RUN, md_release set for exactly the next cycle.
  - Total frozen cycles = MD_CYCLES, counting the detection cycle.
  - md_release blocks re-triggering by the still-present ex_md_start; it clears after one cycle.
  - mem_req is ignored in MD_WAIT; MEM is frozen.
- MEM_WAIT:
  - mem_ready=0: hold outputs, wait counter increments, saturating at 1023. When the counter reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset.
  - mem_ready=1: that cycle is evaluated as RUN using items 2-4 (item 1 is false). Next state is as RUN dictates; wait counter clears.
- stall_count increments on every clock edge with rst_n high and pc_write=0; holds at all-ones.
- An x or z input must never produce pc_write=1 together with pipe_hold=1. This combination is illegal in every state.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for 1 cycle -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1. Repeat with ex_rt=0 -> no stall.
- Branch overrides: ex_branch_taken=1 with a load-use hit in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_count unchanged.
- Mult/div: MD_CYCLES=4, ex_md_start held high -> pipe_hold=1 for exactly 4 cycles, released on the 5th; no re-trigger on the release cycle; stall_count=4.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> hold for 3 cycles. On the ready cycle with ex_branch_taken=1 -> flush that same cycle.
- Timeout: MEM_TIMEOUT=5, mem_ready stuck 0 -> mem_timeout rises after 5 waiting cycles and stays 1 after mem_ready returns. Only rst_n clears it.
- Reset mid-MD_WAIT: assert rst_n=0 asynchronously in cycle 2 of the stall -> outputs take reset values immediately. After release: state RUN, stall_count=0, normal flow.
